log_dumper: RTL and testbench
=============================

LOG_DUMPER -- requirements
Module: log_dumper

Interface
REQ-001 Parameter BRAM_ADDR_WIDTH, default 15: width of the log-memory address; the dump covers 2**BRAM_ADDR_WIDTH words.
REQ-002 Parameter BRAM_DATA_WIDTH, default 16: log word width; only the value 16 is supported.
REQ-003 Parameter MEM_LATENCY, default 1: cycles from address change to valid read data (legal range 1..4).
REQ-004 One clock, clk; reset is asynchronous and active-low, i_rst_n.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  dump request, sampled each cycle.
REQ-008 i_mem_full  input  1  from MEMLog o_mem_full; log capture complete.
REQ-009 o_read_log  output  1  one-cycle pulse to MEMLog i_read_log at dump start.
REQ-010 o_addr_log_to_mem  output  BRAM_ADDR_WIDTH  read address to MEMLog.
REQ-011 i_data_log_from_mem  input  BRAM_DATA_WIDTH  read data from MEMLog.
REQ-012 o_tx_data  output  8  byte toward the UART transmitter.
REQ-013 o_tx_valid  output  1  o_tx_data holds a byte to send.
REQ-014 i_tx_ready  input  1  transmitter accepts a byte when high with o_tx_valid.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, ARM, WAIT, SEND_HI, SEND_LO and DONE.
REQ-018 IDLE: i_start=1 and i_mem_full=1 moves to ARM next cycle; i_start with i_mem_full=0 is ignored.
REQ-019 ARM: o_read_log=1 for exactly this cycle, address = 0, latency counter cleared; next state WAIT.
REQ-020 WAIT: address held; after MEM_LATENCY cycles in WAIT, i_data_log_from_mem is captured into a 16-bit word register; next state SEND_HI.
REQ-021 SEND_HI: o_tx_valid=1, o_tx_data=word[15:8]; a handshake (o_tx_valid & i_tx_ready) moves to SEND_LO.
REQ-022 SEND_LO: o_tx_valid=1, o_tx_data=word[7:0]; on handshake, if address = 2**BRAM_ADDR_WIDTH-1 go to DONE, else increment address and go to WAIT.
REQ-023 DONE: o_done=1 for one cycle, address returns to 0; next state IDLE.
REQ-024 While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid SHALL hold stable; o_tx_valid never drops without a handshake.
REQ-025 o_tx_valid SHALL be 0 in IDLE, ARM, WAIT and DONE.
REQ-026 Byte order: MSB first, one word = two bytes; total bytes per dump = 2*2**BRAM_ADDR_WIDTH.
REQ-027 i_start, and changes on i_mem_full, SHALL be ignored while o_busy=1; a dump always runs to completion.
REQ-028 i_tx_ready held permanently high: each word takes MEM_LATENCY+2 cycles; the address counter never wraps mid-dump.
REQ-029 i_start held high across DONE: a new dump begins from IDLE on the following cycle if i_mem_full=1.

Reset
REQ-030 While i_rst_n=0, regardless of clk: state=IDLE, address=0, word register=0, o_read_log=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0.
REQ-031 A reset asserted mid-dump SHALL abort immediately, with no further handshake completed; after release the block waits in IDLE for a new i_start.

Verification (bench BRAM_ADDR_WIDTH=3, MEM_LATENCY=1, memory model word[i]=16'hA000+i)
REQ-032 Nominal dump: i_mem_full=1, i_start pulse, i_tx_ready=1 -> exactly one o_read_log pulse; 16 bytes A0,00,A0,01,...,A0,07; o_done pulses 1 cycle after byte 16; o_busy high throughout.
REQ-033 Start without full: i_mem_full=0, i_start pulse -> o_busy, o_read_log, o_tx_valid stay 0.
REQ-034 Backpressure: i_tx_ready random at 30% duty -> same 16-byte sequence with no drops or duplicates; o_tx_data stable whenever o_tx_valid=1 and i_tx_ready=0.
REQ-035 Start while busy: extra i_start pulse at byte 5 -> no second o_read_log pulse; exactly 16 bytes and one o_done.
REQ-036 Reset mid-dump: i_rst_n=0 during the SEND_LO of word 3 -> all outputs 0 asynchronously; after release plus a new i_start, the dump restarts at A0,00.
REQ-037 Latency sweep: MEM_LATENCY=3 -> captured bytes still match memory, with 5 cycles per word at i_tx_ready=1.

Source files
------------

// File: rtl/log_dumper.sv
// Streams the whole log memory to a byte-wide UART transmitter, MSB first,
// after a dump request arrives while the log capture is complete.
module log_dumper #(
   parameter int BRAM_ADDR_WIDTH = 15,
   parameter int BRAM_DATA_WIDTH = 16,
   parameter int MEM_LATENCY     = 1
) (
   input  logic                       clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic                       i_mem_full,
   output logic                       o_read_log,
   output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
   input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
   output logic [7:0]                 o_tx_data,
   output logic                       o_tx_valid,
   input  logic                       i_tx_ready,
   output logic                       o_busy,
   output logic                       o_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT, S_SEND_HI, S_SEND_LO, S_DONE
   } state_t;

   localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [2:0]                 LAT_LAST  = 3'(MEM_LATENCY - 1);

   state_t                       r_state, w_next;
   logic [BRAM_ADDR_WIDTH-1:0]   r_addr;
   logic [BRAM_DATA_WIDTH-1:0]   r_word;
   logic [2:0]                   r_lat;
   logic                         w_lat_done;
   logic                         w_last;

   assign w_lat_done        = (r_lat == LAT_LAST);
   assign w_last            = (r_addr == LAST_ADDR);
   assign o_addr_log_to_mem = r_addr;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Outputs decode from state only, so reset drives them all low at once.
   always_comb begin
      w_next     = r_state;
      o_read_log = 1'b0;
      o_tx_valid = 1'b0;
      o_tx_data  = 8'h00;
      o_busy     = 1'b1;
      o_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start && i_mem_full) w_next = S_ARM;
         end
         S_ARM: begin
            o_read_log = 1'b1;
            w_next     = S_WAIT;
         end
         S_WAIT: begin
            if (w_lat_done) w_next = S_SEND_HI;
         end
         S_SEND_HI: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_word[15:8];
            if (i_tx_ready) w_next = S_SEND_LO;
         end
         S_SEND_LO: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_word[7:0];
            if (i_tx_ready) w_next = w_last ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            o_busy = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr <= '0;
         r_word <= '0;
         r_lat  <= '0;
      end else begin
         case (r_state)
            S_ARM: begin
               r_addr <= '0;
               r_lat  <= '0;
            end
            S_WAIT: begin
               r_lat <= r_lat + 3'd1;
               if (w_lat_done) r_word <= i_data_log_from_mem;
            end
            S_SEND_LO: begin
               // The address stops at the last word; DONE clears it.
               if (i_tx_ready && !w_last) begin
                  r_addr <= r_addr + 1'b1;
                  r_lat  <= '0;
               end
            end
            S_DONE:  r_addr <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_log_dumper.sv
// Bench for log_dumper: two instances (read latency 1 and 3) share stimulus;
// each accepted byte stream is compared with the memory contents word[i]=A000+i.
module tb_log_dumper;

   localparam int AW     = 3;
   localparam int NWORDS = 1 << AW;
   localparam int NBYTES = 2 * NWORDS;

   logic clk, rst_n, start, full, rdy;
   logic [7:0]    txd   [2];
   logic          txv   [2];
   logic          rl    [2];
   logic          dn    [2];
   logic          bsy   [2];
   logic [AW-1:0] addr  [2];
   logic [15:0]   rdata [2];
   logic [15:0]   p3a, p3b;

   int nvec = 0;
   int nerr = 0;

   log_dumper #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(16), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mem_full(full),
      .o_read_log(rl[0]), .o_addr_log_to_mem(addr[0]), .i_data_log_from_mem(rdata[0]),
      .o_tx_data(txd[0]), .o_tx_valid(txv[0]), .i_tx_ready(rdy),
      .o_busy(bsy[0]), .o_done(dn[0]));

   log_dumper #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(16), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mem_full(full),
      .o_read_log(rl[1]), .o_addr_log_to_mem(addr[1]), .i_data_log_from_mem(rdata[1]),
      .o_tx_data(txd[1]), .o_tx_valid(txv[1]), .i_tx_ready(rdy),
      .o_busy(bsy[1]), .o_done(dn[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: data settles within MEM_LATENCY edges of an address change.
   assign rdata[0] = 16'hA000 + 16'(addr[0]);
   always @(posedge clk) begin
      p3a <= 16'hA000 + 16'(addr[1]);
      p3b <= p3a;
   end
   assign rdata[1] = p3b;

   // Monitors: accepted bytes with timestamps, pulse counts, protocol errors.
   logic [7:0] g0[$], g1[$];
   int t0[$], t1[$];
   int cyc = 0;
   int rlc[2], dnc[2], dcyc[2], stab[2], berr[2];
   logic phold[2], indump[2];
   logic [7:0] pdat[2];
   initial for (int d = 0; d < 2; d++) begin
      rlc[d] = 0; dnc[d] = 0; dcyc[d] = 0; stab[d] = 0; berr[d] = 0;
      phold[d] = 0; indump[d] = 0; pdat[d] = 0;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (txv[0] && rdy) begin g0.push_back(txd[0]); t0.push_back(cyc); end
      if (txv[1] && rdy) begin g1.push_back(txd[1]); t1.push_back(cyc); end
      for (int d = 0; d < 2; d++) begin
         if (rl[d]) rlc[d] <= rlc[d] + 1;
         if (dn[d]) begin dnc[d] <= dnc[d] + 1; dcyc[d] <= cyc; end
         if (rst_n && phold[d] && (!txv[d] || txd[d] != pdat[d])) stab[d] <= stab[d] + 1;
         phold[d] <= txv[d] && !rdy;
         pdat[d]  <= txd[d];
         if (rst_n && indump[d] && !bsy[d]) berr[d] <= berr[d] + 1;
         indump[d] <= !rst_n ? 1'b0 : rl[d] ? 1'b1 : dn[d] ? 1'b0 : indump[d];
      end
   end

   task automatic chk(input string nm, input int got_v, input int exp_v);
      nvec++;
      if (got_v != exp_v) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, got_v, exp_v);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int k);
      logic [15:0] w;
      w = 16'hA000 + 16'(k / 2);
      return (k % 2) ? w[7:0] : w[15:8];
   endfunction

   function automatic int qsize(input int d);
      return d ? g1.size() : g0.size();
   endfunction

   function automatic int qbyte(input int d, input int k);
      return d ? int'(g1[k]) : int'(g0[k]);
   endfunction

   function automatic int qtime(input int d, input int k);
      return d ? t1[k] : t0[k];
   endfunction

   int bq[2], brl[2], bdn[2], bst[2], bbe[2];
   task automatic snap();
      for (int d = 0; d < 2; d++) begin
         bq[d] = qsize(d); brl[d] = rlc[d]; bdn[d] = dnc[d];
         bst[d] = stab[d]; bbe[d] = berr[d];
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs until both instances report done; optionally injects a start mid-dump.
   task automatic wait_done(input bit rnd, input int inj_at);
      bit ok, injected;
      ok = 0; injected = 0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         rdy   = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         start = 1'b0;
         if (inj_at >= 0 && !injected && qsize(0) - bq[0] == inj_at) begin
            start = 1'b1; injected = 1;
         end
         @(negedge clk);
         ok = (dnc[0] > bdn[0]) && (dnc[1] > bdn[1]) && !bsy[0] && !bsy[1];
      end
      start = 1'b0;
      chk("dump_completes", int'(ok), 1);
   endtask

   task automatic check_dump(input int d, input bit timing);
      int n;
      n = qsize(d) - bq[d];
      chk($sformatf("byte_count[%0d]", d), n, NBYTES);
      for (int k = 0; k < NBYTES && k < n; k++)
         chk($sformatf("byte[%0d][%0d]", d, k), qbyte(d, bq[d] + k), int'(exp_byte(k)));
      chk($sformatf("read_log_pulses[%0d]", d), rlc[d] - brl[d], 1);
      chk($sformatf("done_pulses[%0d]", d), dnc[d] - bdn[d], 1);
      chk($sformatf("tx_stable[%0d]", d), stab[d] - bst[d], 0);
      chk($sformatf("busy_throughout[%0d]", d), berr[d] - bbe[d], 0);
      if (timing && n == NBYTES) begin
         chk($sformatf("done_after_last[%0d]", d), dcyc[d] - qtime(d, bq[d] + NBYTES - 1), 1);
         chk($sformatf("cycles_per_word[%0d]", d),
             qtime(d, bq[d] + 3) - qtime(d, bq[d] + 1), d ? 5 : 3);
         chk($sformatf("cycles_per_word_last[%0d]", d),
             qtime(d, bq[d] + NBYTES - 1) - qtime(d, bq[d] + NBYTES - 3), d ? 5 : 3);
      end
   endtask

   task automatic check_quiet(input int d, input string nm);
      chk({nm, "_busy"}, int'(bsy[d]), 0);
      chk({nm, "_read_log"}, int'(rl[d]), 0);
      chk({nm, "_valid"}, int'(txv[d]), 0);
      chk({nm, "_data"}, int'(txd[d]), 0);
      chk({nm, "_done"}, int'(dn[d]), 0);
      chk({nm, "_addr"}, int'(addr[d]), 0);
   endtask

   typedef struct {
      logic       start, full, rdy;
      logic       busy, rl, v, done;
      logic [7:0] d;
      logic [2:0] a;
   } vec_t;
   vec_t tv[12];

   initial begin
      int n7;
      // Latency-1 instance, cycle by cycle from IDLE.
      tv[0]  = '{0, 0, 1,  0, 0, 0, 0, 8'h00, 3'd0};
      tv[1]  = '{1, 0, 1,  0, 0, 0, 0, 8'h00, 3'd0};
      tv[2]  = '{1, 1, 1,  1, 1, 0, 0, 8'h00, 3'd0};
      tv[3]  = '{0, 1, 1,  1, 0, 0, 0, 8'h00, 3'd0};
      tv[4]  = '{0, 1, 1,  1, 0, 1, 0, 8'hA0, 3'd0};
      tv[5]  = '{0, 1, 0,  1, 0, 1, 0, 8'hA0, 3'd0};
      tv[6]  = '{0, 1, 1,  1, 0, 1, 0, 8'h00, 3'd0};
      tv[7]  = '{0, 1, 1,  1, 0, 0, 0, 8'h00, 3'd1};
      tv[8]  = '{0, 1, 1,  1, 0, 1, 0, 8'hA0, 3'd1};
      tv[9]  = '{0, 1, 1,  1, 0, 1, 0, 8'h01, 3'd1};
      tv[10] = '{0, 0, 0,  1, 0, 1, 0, 8'h01, 3'd1};
      tv[11] = '{1, 1, 0,  1, 0, 1, 0, 8'h01, 3'd1};

      rst_n = 1'b0; start = 1'b0; full = 1'b0; rdy = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) check_quiet(d, $sformatf("reset[%0d]", d));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Vector table, then let the dump finish with ready held high.
      snap();
      for (int i = 0; i < 12; i++) begin
         start = tv[i].start; full = tv[i].full; rdy = tv[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_busy", i), int'(bsy[0]), int'(tv[i].busy));
         chk($sformatf("vec%0d_read_log", i), int'(rl[0]), int'(tv[i].rl));
         chk($sformatf("vec%0d_valid", i), int'(txv[0]), int'(tv[i].v));
         chk($sformatf("vec%0d_data", i), int'(txd[0]), int'(tv[i].d));
         chk($sformatf("vec%0d_done", i), int'(dn[0]), int'(tv[i].done));
         chk($sformatf("vec%0d_addr", i), int'(addr[0]), int'(tv[i].a));
      end
      start = 1'b0; full = 1'b1;
      wait_done(0, -1);
      for (int d = 0; d < 2; d++) check_dump(d, 0);

      // Start without a full log is ignored.
      full = 1'b0;
      pulse_start();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("nofull_busy[%0d]", d), int'(bsy[d]), 0);
            chk($sformatf("nofull_read_log[%0d]", d), int'(rl[d]), 0);
            chk($sformatf("nofull_valid[%0d]", d), int'(txv[d]), 0);
         end
      end

      // Nominal dump with ready high: stream, done timing, per-word cycles.
      full = 1'b1; rdy = 1'b1;
      snap();
      pulse_start();
      wait_done(0, -1);
      for (int d = 0; d < 2; d++) check_dump(d, 1);

      // Random backpressure at ~30% ready duty.
      snap();
      pulse_start();
      wait_done(1, -1);
      for (int d = 0; d < 2; d++) check_dump(d, 0);

      // Extra start while busy at byte 5.
      snap();
      pulse_start();
      wait_done(1, 5);
      for (int d = 0; d < 2; d++) check_dump(d, 0);

      // Reset during SEND_LO of word 3.
      snap();
      rdy = 1'b1;
      pulse_start();
      begin
         bit hit;
         hit = 0;
         for (int c = 0; c < 500 && !hit; c++) begin
            if (txv[0] && txd[0] == 8'h03) hit = 1;
            else @(negedge clk);
         end
         chk("reached_word3_lo", int'(hit), 1);
      end
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) check_quiet(d, $sformatf("midreset[%0d]", d));
      n7 = qsize(0) - bq[0];
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) @(negedge clk);
      chk("reset_bytes_before_abort", n7, 7);
      chk("reset_no_more_bytes", qsize(0) - bq[0], 7);
      for (int d = 0; d < 2; d++) check_quiet(d, $sformatf("postreset_idle[%0d]", d));

      // Restart after reset begins again at A0,00.
      snap();
      pulse_start();
      wait_done(0, -1);
      for (int d = 0; d < 2; d++) check_dump(d, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
